two_bit_mux_scanner: RTL
========================

TWO_BIT_MUX_SCANNER -- requirements
Module: two_bit_mux_scanner

Interface
REQ-001 SHALL have parameter DWELL, default 4, meaning clock cycles spent on each select value; legal range 2..255.
REQ-002 SHALL have parameter SETTLE, default 1, meaning the cycle index within a dwell at which m_in is sampled; legal range 0..DWELL-1.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, scanning permitted while 1.
REQ-006 SHALL have port sel, output, 2, channel select driven to the downstream 2-bit 4-to-1 mux s input.
REQ-007 SHALL have port m_in, input, 2, the mux output m for the currently selected channel.
REQ-008 SHALL have port snap, output, 8, last accepted frame; channel i at bits [2i+1:2i].
REQ-009 SHALL have port frame_valid, output, 1, snap holds a new frame not yet accepted.
REQ-010 SHALL have port frame_ready, input, 1, consumer accepts the frame.
REQ-011 SHALL have port frame_changed, output, 1, qualifies frame_valid: frame differs from the previously accepted frame.

Function
REQ-012 SHALL implement FSM states IDLE, SCAN, FRAME.
REQ-013 SHALL, in IDLE, hold sel=0 and dwell counter=0, moving to SCAN on the first edge with enable=1.
REQ-014 SHALL, in SCAN, increment the dwell counter each cycle from 0 to DWELL-1, then wrap to 0.
REQ-015 SHALL capture m_in into shadow[sel] on the edge where the dwell counter equals SETTLE.
REQ-016 SHALL, on dwell counter wrap with sel<3, increment sel by 1.
REQ-017 SHALL, on dwell counter wrap with sel=3, load snap from shadow (including a same-edge capture), set frame_valid=1, set frame_changed per REQ-019, and enter FRAME.
REQ-018 SHALL give first frame_valid exactly 4*DWELL cycles after the first SCAN cycle.
REQ-019 SHALL set frame_changed=1 if the new frame differs from the last accepted frame in any bit, or if no frame has been accepted since reset.
REQ-020 SHALL, in FRAME, hold sel=3, snap, frame_valid and frame_changed stable until frame_valid and frame_ready are both 1 on an edge.
REQ-021 SHALL, on handshake, record snap as the last accepted frame, clear frame_valid and frame_changed, set sel=0 and dwell counter=0, then enter SCAN if enable=1, else IDLE.
REQ-022 SHALL complete the handshake on the first FRAME edge when frame_ready is already 1 (no minimum wait).
REQ-023 SHALL, on enable=0 during SCAN, enter IDLE on that edge, discard the partial shadow, and leave the last accepted frame unchanged.
REQ-024 SHALL ignore enable while in FRAME; deassertion takes effect only at handshake per REQ-021.
REQ-025 SHALL ignore frame_ready outside FRAME.

Reset
REQ-026 SHALL, while resetn=0, force state=IDLE, sel=0, dwell counter=0, shadow=0, snap=0, last accepted frame=0, frame_valid=0, frame_changed=0, and the "accepted since reset" flag=0, independent of clock.
REQ-027 SHALL apply reset mid-operation, including in FRAME, by dropping any pending frame without a handshake.
REQ-028 SHALL, after resetn rises, wait for an edge with enable=1 before starting scanning.

Structure
REQ-029 SHALL take state encoding, CHANNELS=4 and CH_WIDTH=2 from shared package two_bit_mux_pkg.
REQ-030 SHALL place the dwell counter, with wrap and sample-strobe outputs, in sub-module dwell_counter.
REQ-031 SHALL contain no combinational path from m_in to any output.

Verification (DWELL=4, SETTLE=1)
REQ-032 SHALL cover: m_in follows sel from channel values {0,1,2,3}, enable=1, frame_ready=1 -> frame_valid pulses 16 cycles after SCAN entry, snap=8'hE4, frame_changed=1.
REQ-033 SHALL cover: same inputs for a second frame -> snap=8'hE4, frame_changed=0, frame period 17 cycles including handshake.
REQ-034 SHALL cover: frame_ready=0 for 10 cycles after frame_valid -> sel stays 3, snap stable, no capture; one cycle after ready=1, frame_valid=0 and sel=0.
REQ-035 SHALL cover: enable dropped at dwell 2 of channel 1 -> IDLE next edge; re-enable leads to a full 16-cycle scan from channel 0.
REQ-036 SHALL cover: resetn pulsed low while in FRAME -> all outputs 0 immediately; next accepted frame reports frame_changed=1.
REQ-037 SHALL cover: channel 2 toggled from 2'b10 to 2'b01 between frames -> second frame snap=8'hD4, frame_changed=1.

Source files
------------

// File: rtl/two_bit_mux_pkg.sv
// Shared types and sizing for the 2-bit 4-to-1 mux scanner.
// The state encoding and channel geometry live here so the scanner and its consumers agree.
package two_bit_mux_pkg;

    localparam int CHANNELS    = 4;
    localparam int CH_WIDTH    = 2;
    localparam int SEL_WIDTH   = 2;
    localparam int FRAME_WIDTH = CHANNELS * CH_WIDTH;
    localparam int CNT_WIDTH   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        FRAME = 2'd2
    } scan_state_e;

    typedef logic [CH_WIDTH-1:0]    chan_t;
    typedef logic [SEL_WIDTH-1:0]   sel_t;
    typedef logic [FRAME_WIDTH-1:0] frame_t;

    localparam sel_t LAST_SEL = sel_t'(CHANNELS - 1);

endpackage

// File: rtl/two_bit_mux_scanner_dwell_counter.sv
// Per-channel dwell counter: counts 0..DWELL-1 while run is high and flags the
// wrap cycle and the settle (sample) cycle. Flags are unqualified; the caller gates them.
module dwell_counter
    import two_bit_mux_pkg::*;
#(
    parameter int DWELL  = 4,
    parameter int SETTLE = 1
)
(
    input  logic clock,
    input  logic resetn,
    input  logic run,
    input  logic clear,
    output logic wrap,
    output logic strobe
);

    localparam logic [CNT_WIDTH-1:0] LAST_COUNT   = CNT_WIDTH'(DWELL - 1);
    localparam logic [CNT_WIDTH-1:0] SAMPLE_COUNT = CNT_WIDTH'(SETTLE);

    logic [CNT_WIDTH-1:0] count_reg;
    logic [CNT_WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (run) begin
            count_next = (count_reg == LAST_COUNT) ? '0 : count_reg + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign wrap   = (count_reg == LAST_COUNT);
    assign strobe = (count_reg == SAMPLE_COUNT);

endmodule

// File: rtl/two_bit_mux_scanner.sv
// Walks a downstream 4-to-1 mux through its channels, samples each after a settle
// delay and offers the assembled 8-bit frame to a consumer with a valid/ready handshake.
module two_bit_mux_scanner
    import two_bit_mux_pkg::*;
#(
    parameter int DWELL  = 4,
    parameter int SETTLE = 1
)
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    output logic [1:0] sel,
    input  logic [1:0] m_in,
    output logic [7:0] snap,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       frame_changed
);

    scan_state_e state_reg, state_next;
    sel_t        sel_reg, sel_next;
    frame_t      snap_reg, snap_next;
    frame_t      last_reg, last_next;
    logic        valid_reg, valid_next;
    logic        changed_reg, changed_next;
    logic        accepted_reg, accepted_next;

    logic        cnt_run;
    logic        cnt_clear;
    logic        dwell_wrap;
    logic        dwell_strobe;
    logic        capture_en;
    logic        shadow_clear;
    frame_t      frame_now;

    dwell_counter #(
        .DWELL  (DWELL),
        .SETTLE (SETTLE)
    ) u_dwell (
        .clock  (clock),
        .resetn (resetn),
        .run    (cnt_run),
        .clear  (cnt_clear),
        .wrap   (dwell_wrap),
        .strobe (dwell_strobe)
    );

    // frame_now is the shadow as it will look after this edge, so a capture on
    // the wrap edge of the last channel still lands in the published frame.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            chan_t shadow_reg;
            logic  hit;

            assign hit = dwell_strobe && (sel_reg == sel_t'(gi));

            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    shadow_reg <= '0;
                end else if (shadow_clear) begin
                    shadow_reg <= '0;
                end else if (capture_en && hit) begin
                    shadow_reg <= m_in;
                end
            end

            assign frame_now[gi*CH_WIDTH +: CH_WIDTH] = hit ? m_in : shadow_reg;
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        sel_next      = sel_reg;
        snap_next     = snap_reg;
        last_next     = last_reg;
        valid_next    = valid_reg;
        changed_next  = changed_reg;
        accepted_next = accepted_reg;
        cnt_run       = 1'b0;
        cnt_clear     = 1'b0;
        capture_en    = 1'b0;
        shadow_clear  = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_clear = 1'b1;
                sel_next  = '0;
                if (enable) begin
                    state_next = SCAN;
                end
            end

            SCAN: begin
                if (!enable) begin
                    state_next   = IDLE;
                    sel_next     = '0;
                    cnt_clear    = 1'b1;
                    shadow_clear = 1'b1;
                end else begin
                    cnt_run    = 1'b1;
                    capture_en = 1'b1;
                    if (dwell_wrap) begin
                        if (sel_reg != LAST_SEL) begin
                            sel_next = sel_reg + sel_t'(1);
                        end else begin
                            snap_next    = frame_now;
                            valid_next   = 1'b1;
                            changed_next = !accepted_reg || (frame_now != last_reg);
                            state_next   = FRAME;
                        end
                    end
                end
            end

            FRAME: begin
                // Everything is frozen here; enable only matters once the frame is taken.
                cnt_clear = 1'b1;
                if (valid_reg && frame_ready) begin
                    last_next     = snap_reg;
                    accepted_next = 1'b1;
                    valid_next    = 1'b0;
                    changed_next  = 1'b0;
                    sel_next      = '0;
                    state_next    = enable ? SCAN : IDLE;
                end
            end

            default: begin
                state_next = IDLE;
                sel_next   = '0;
                cnt_clear  = 1'b1;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            sel_reg      <= '0;
            snap_reg     <= '0;
            last_reg     <= '0;
            valid_reg    <= 1'b0;
            changed_reg  <= 1'b0;
            accepted_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            sel_reg      <= sel_next;
            snap_reg     <= snap_next;
            last_reg     <= last_next;
            valid_reg    <= valid_next;
            changed_reg  <= changed_next;
            accepted_reg <= accepted_next;
        end
    end

    assign sel           = sel_reg;
    assign snap          = snap_reg;
    assign frame_valid   = valid_reg;
    assign frame_changed = changed_reg;

endmodule
